// File: rtl/enemy_missile_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : enemy_missile_dispatcher
// Brief    : Paces enemy missile launches within a wave, samples the target
//            index, maps it to an impact x, picks the lowest free slot and
//            offers one launch record at a time over a valid/ack handshake.
// Revision : 1.0  initial release
// ============================================================================
module enemy_missile_dispatcher #(
  parameter int NUM_SLOTS      = 4,
  parameter int WAVE_COUNT     = 8,
  parameter int SPAWN_INTERVAL = 30,
  parameter int SCREEN_W       = 640,
  parameter int TGT_X0         = 120,
  parameter int TGT_X1         = 320,
  parameter int TGT_X2         = 520
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [2:0]           target_sel,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 launch_ack,
  output logic                 launch_valid,
  output logic [2:0]           launch_slot,
  output logic [9:0]           launch_start_x,
  output logic [9:0]           launch_target_x,
  output logic [7:0]           launched_cnt,
  output logic                 wave_done
);

  localparam logic [7:0] c_interval = 8'(SPAWN_INTERVAL);
  localparam logic [7:0] c_wave     = 8'(WAVE_COUNT);
  localparam logic [9:0] c_sx_max   = 10'(SCREEN_W - 1);
  localparam logic [9:0] c_tgt_x0   = 10'(TGT_X0);
  localparam logic [9:0] c_tgt_x1   = 10'(TGT_X1);
  localparam logic [9:0] c_tgt_x2   = 10'(TGT_X2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SELECT = 3'd2,
    S_LAUNCH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_interval;
  logic [9:0] r_start_x;
  logic [2:0] r_slot;
  logic [9:0] r_launch_sx;
  logic [9:0] r_launch_tx;
  logic [7:0] r_cnt;

  logic       w_free_any;
  logic [2:0] w_free_idx;
  logic [9:0] w_tgt_x;
  logic       w_tsel_ok;
  logic       w_xfer;
  logic [7:0] w_cnt_inc;
  logic       w_last;
  logic       w_reload;
  logic       w_tick_dec;
  logic       w_capture;

  assign w_tsel_ok = (target_sel <= 3'd2);
  assign w_xfer    = (r_state == S_LAUNCH) && launch_ack;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_last    = (w_cnt_inc == c_wave);

  // Lowest-index free slot: scan downwards so the lowest free index is written last.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = 3'(i);
      end
    end
  end

  // Map the legal target indices onto their impact x-coordinates.
  always_comb begin
    w_tgt_x = 10'd0;
    case (target_sel)
      3'd0:    w_tgt_x = c_tgt_x0;
      3'd1:    w_tgt_x = c_tgt_x1;
      3'd2:    w_tgt_x = c_tgt_x2;
      default: w_tgt_x = 10'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_reload     = 1'b0;
    w_tick_dec   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_WAIT;
          w_reload     = 1'b1;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (frame_tick) begin
          w_tick_dec = 1'b1;
          if (r_interval <= 8'd1) begin
            w_state_next = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (w_tsel_ok && w_free_any) begin
          w_capture    = 1'b1;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // A record once offered is never withdrawn; exit only on transfer.
        if (launch_ack) begin
          if (w_last) begin
            w_state_next = S_DONE;
          end else if (!enable) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT;
            w_reload     = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Start-x counter, launch pacing counter, payload capture and launch count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_x   <= 10'd0;
      r_interval  <= 8'd0;
      r_slot      <= 3'd0;
      r_launch_sx <= 10'd0;
      r_launch_tx <= 10'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_start_x <= (r_start_x == c_sx_max) ? 10'd0 : r_start_x + 10'd1;

      if (w_reload) begin
        r_interval <= c_interval;
      end else if (w_tick_dec) begin
        r_interval <= r_interval - 8'd1;
      end

      if (w_capture) begin
        r_slot      <= w_free_idx;
        r_launch_tx <= w_tgt_x;
        r_launch_sx <= r_start_x;
      end

      if (r_state == S_IDLE) begin
        r_cnt <= 8'd0;
      end else if (w_xfer) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign launch_valid    = (r_state == S_LAUNCH);
  assign wave_done       = (r_state == S_DONE);
  assign launch_slot     = r_slot;
  assign launch_start_x  = r_launch_sx;
  assign launch_target_x = r_launch_tx;
  assign launched_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enemy_missile_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_missile_dispatcher
// Brief    : Self-checking bench; directed wave start followed by randomized
//            stimulus compared every cycle against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_enemy_missile_dispatcher;

  localparam int c_slots = 4;
  localparam int c_wave  = 3;
  localparam int c_spawn = 2;
  localparam int c_scr_w = 640;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] target_sel = 3'd0;
  logic [3:0] slot_busy = 4'd0;
  logic       launch_ack = 1'b0;
  logic       launch_valid;
  logic [2:0] launch_slot;
  logic [9:0] launch_start_x;
  logic [9:0] launch_target_x;
  logic [7:0] launched_cnt;
  logic       wave_done;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model of the wave: what is pending, how many ticks remain, etc.
  int m_sx, m_ticks, m_cnt, m_slot, m_stx, m_tx;
  bit m_armed, m_offer, m_finished;
  int tgt_tab[3] = '{120, 320, 520};

  enemy_missile_dispatcher #(
    .NUM_SLOTS(c_slots), .WAVE_COUNT(c_wave), .SPAWN_INTERVAL(c_spawn),
    .SCREEN_W(c_scr_w), .TGT_X0(120), .TGT_X1(320), .TGT_X2(520)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .target_sel(target_sel), .slot_busy(slot_busy), .launch_ack(launch_ack),
    .launch_valid(launch_valid), .launch_slot(launch_slot),
    .launch_start_x(launch_start_x), .launch_target_x(launch_target_x),
    .launched_cnt(launched_cnt), .wave_done(wave_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int sx_now;
    if (rst) begin
      m_sx = 0; m_ticks = 0; m_cnt = 0; m_slot = 0; m_stx = 0; m_tx = 0;
      m_armed = 0; m_offer = 0; m_finished = 0;
      return;
    end
    sx_now = m_sx;
    m_sx = (m_sx + 1) % c_scr_w;
    if (m_offer) begin
      if (launch_ack) begin
        m_offer = 0;
        m_cnt++;
        if (m_cnt == c_wave) m_finished = 1;
        else if (enable) begin m_armed = 1; m_ticks = c_spawn; end
        else m_armed = 0;
      end
    end else if (m_finished) begin
      if (!enable) m_finished = 0;
    end else if (!m_armed) begin
      m_cnt = 0;
      if (enable) begin m_armed = 1; m_ticks = c_spawn; end
    end else if (!enable) begin
      m_armed = 0;
    end else if (m_ticks > 0) begin
      if (frame_tick) m_ticks--;
    end else if (target_sel <= 2 && slot_busy != 4'hF) begin
      bit found = 0;
      for (int i = 0; i < c_slots; i++)
        if (!found && !slot_busy[i]) begin m_slot = i; found = 1; end
      m_tx = tgt_tab[target_sel];
      m_stx = sx_now;
      m_offer = 1;
      m_armed = 0;
    end
  endtask

  task automatic compare_all();
    chk("launch_valid", launch_valid, m_offer);
    chk("launch_slot", launch_slot, m_slot);
    chk("launch_start_x", launch_start_x, m_stx);
    chk("launch_target_x", launch_target_x, m_tx);
    chk("launched_cnt", launched_cnt, m_cnt);
    chk("wave_done", wave_done, m_finished);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    bit seen_first;
    bit seen_done;
    seen_first = 0;
    seen_done  = 0;

    // Reset, then a wave with steady target 1, all slots free, ack held.
    rst = 1; enable = 0;
    cycle(); cycle();
    chk("reset_valid", launch_valid, 0);
    chk("reset_cnt", launched_cnt, 0);
    rst = 0; enable = 1; target_sel = 3'd1; slot_busy = 4'd0; launch_ack = 1;
    for (int k = 0; k < 60; k++) begin
      frame_tick = (k % 4 == 0);
      cycle();
      if (launch_valid && !seen_first) begin
        seen_first = 1;
        chk("t1_first_slot", launch_slot, 0);
        chk("t1_first_tx", launch_target_x, 320);
      end
      if (wave_done) seen_done = 1;
    end
    chk("t1_launch_seen", seen_first, 1);
    chk("t1_wave_done_seen", seen_done, 1);
    chk("t1_cnt_at_done", launched_cnt, c_wave);

    // Drop enable in DONE: back to idle with the count cleared.
    enable = 0; frame_tick = 0;
    cycle(); cycle();
    chk("t5_idle_cnt", launched_cnt, 0);
    chk("t5_idle_done", wave_done, 0);

    // Randomized: rotating targets, busy slots, withheld acks, enable drops, resets.
    for (int k = 0; k < 5000; k++) begin
      rst        = ($urandom % 250 == 0);
      enable     = ($urandom % 50 != 0);
      frame_tick = ($urandom % 3 == 0);
      target_sel = 3'($urandom % 8);
      slot_busy  = ($urandom % 3 == 0) ? 4'hF : 4'($urandom % 16);
      launch_ack = ($urandom % 3 == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
